// File: rtl/addsub_serial_nbit.sv
// Purpose : digit-serial two's-complement adder/subtractor, D bits per cycle over N/D cycles.
// Latency : start sampled at edge E0, result and done valid in the cycle after edge E(N/D).
// Backpr. : none; start is ignored while busy, and a start seen in DONE chains with no idle bubble.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start           request a new operation (sampled in IDLE or DONE)
//   x, y, add_n     operands and mode (0 = x+y, 1 = x-y), sampled with start
//   busy            high while digits are being processed
//   done            one-cycle pulse when s/c_out/ovf are updated
//   s, c_out, ovf   result mod 2^N, raw MSB carry-out, signed overflow
module addsub_serial_nbit #(
    parameter int N = 16,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         add_n,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] s,
    output logic         c_out,
    output logic         ovf
);

    localparam int NDIG = N / D;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   xa_q, xa_d;
    logic [N-1:0]   yb_q, yb_d;
    logic [N-1:0]   acc_q, acc_d;
    logic           carry_q, carry_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   s_q, s_d;
    logic           c_out_q, c_out_d;
    logic           ovf_q, ovf_d;

    logic [D:0]     dig_sum;
    logic           c_msb_in;
    logic           last_dig;
    logic [N-1:0]   acc_shift;

    // Digit adder: low D bits of the shifting operands plus the running carry.
    assign dig_sum  = {1'b0, xa_q[D-1:0]} + {1'b0, yb_q[D-1:0]} + {{D{1'b0}}, carry_q};
    // Carry into the top bit of this digit, recovered from sum = a ^ b ^ cin.
    // On the last digit that top bit is bit N-1 of the word.
    assign c_msb_in = dig_sum[D-1] ^ xa_q[D-1] ^ yb_q[D-1];
    assign last_dig = (cnt_q == CW'(NDIG - 1));

    // Result digits enter from the MSB side so the first (least significant)
    // digit ends up at the bottom after N/D shifts.
    generate
        if (D == N) begin : g_single
            assign acc_shift = dig_sum[D-1:0];
        end else begin : g_multi
            assign acc_shift = {dig_sum[D-1:0], acc_q[N-1:D]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        xa_d    = xa_q;
        yb_d    = yb_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // Subtract as x + ~y + 1: invert y and seed the carry.
                    xa_d    = x;
                    yb_d    = y ^ {N{add_n}};
                    carry_d = add_n;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                xa_d    = xa_q >> D;
                yb_d    = yb_q >> D;
                acc_d   = acc_shift;
                carry_d = dig_sum[D];
                cnt_d   = cnt_q + CW'(1);
                if (last_dig) begin
                    s_d     = acc_shift;
                    c_out_d = dig_sum[D];
                    ovf_d   = c_msb_in ^ dig_sum[D];
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            xa_q    <= '0;
            yb_q    <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            xa_q    <= xa_d;
            yb_q    <= yb_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign s     = s_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_addsub_serial_nbit.sv
module tb_addsub_serial_nbit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] x, y;
    logic        add_n;
    logic        busy, done;
    logic [15:0] s;
    logic        c_out, ovf;

    logic        sw_reset, sw_start, sw_add;
    logic [7:0]  sw_x, sw_y;
    logic [3:0]  sw_busy, sw_done, sw_c, sw_o;
    logic [7:0]  sw_s [4];

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_s_held;

    always #5 clk = ~clk;

    addsub_serial_nbit #(.N(16), .D(4)) dut (
        .clk(clk), .reset(reset), .start(start), .x(x), .y(y), .add_n(add_n),
        .busy(busy), .done(done), .s(s), .c_out(c_out), .ovf(ovf)
    );

    for (genvar g = 0; g < 4; g++) begin : g_sw
        addsub_serial_nbit #(.N(8), .D(1 << g)) u_sw (
            .clk(clk), .reset(sw_reset), .start(sw_start), .x(sw_x), .y(sw_y), .add_n(sw_add),
            .busy(sw_busy[g]), .done(sw_done[g]), .s(sw_s[g]), .c_out(sw_c[g]), .ovf(sw_o[g])
        );
    end

    // Reference: plain integer arithmetic on n-bit words.
    function automatic void model(input int n, input longint xv, input longint yv, input bit sub,
                                  output longint sv, output bit cv, output bit ov);
        longint m, h, sx, sy, r, sr;
        m  = longint'(1) << n;
        h  = m / 2;
        sx = (xv >= h) ? xv - m : xv;
        sy = (yv >= h) ? yv - m : yv;
        if (sub) begin
            r  = xv - yv;
            cv = (xv >= yv);
            sr = sx - sy;
        end else begin
            r  = xv + yv;
            cv = (r >= m);
            sr = sx + sy;
        end
        sv = ((r % m) + m) % m;
        ov = (sr < -h) || (sr > h - 1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge with the DUT in IDLE or DONE. hold=1 keeps start
    // high so the next call chains back-to-back from DONE.
    task automatic run_op(input logic [15:0] xv, input logic [15:0] yv, input bit sub, input bit hold);
        longint es;
        bit ec, eo;
        model(16, longint'(xv), longint'(yv), sub, es, ec, eo);
        x = xv; y = yv; add_n = sub; start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("busy_run", busy, 1);
            chk("done_run", done, 0);
            chk("s_hold_run", s, exp_s_held);
            x = 16'($urandom); y = 16'($urandom); add_n = 1'($urandom);
            if (!hold) start = 1'($urandom);
        end
        @(negedge clk);
        chk("done_pulse", done, 1);
        chk("busy_done", busy, 0);
        chk("s", s, es);
        chk("c_out", c_out, ec);
        chk("ovf", ovf, eo);
        exp_s_held = 16'(es);
        if (!hold) begin
            start = 1'b0;
            @(negedge clk);
            chk("busy_idle", busy, 0);
            chk("done_idle", done, 0);
            chk("s_hold_idle", s, exp_s_held);
        end
    endtask

    task automatic sweep_op(input logic [7:0] xv, input logic [7:0] yv, input bit sub);
        int   first [4];
        logic [7:0] rs [4];
        logic rc [4];
        logic ro [4];
        longint es;
        bit ec, eo;
        model(8, longint'(xv), longint'(yv), sub, es, ec, eo);
        sw_x = xv; sw_y = yv; sw_add = sub; sw_start = 1'b1;
        @(negedge clk);
        sw_start = 1'b0;
        for (int g = 0; g < 4; g++) begin
            first[g] = 0; rs[g] = 'x; rc[g] = 1'bx; ro[g] = 1'bx;
        end
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            for (int g = 0; g < 4; g++) begin
                if (sw_done[g] && first[g] == 0) begin
                    first[g] = k; rs[g] = sw_s[g]; rc[g] = sw_c[g]; ro[g] = sw_o[g];
                end
            end
        end
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("sw_lat_D%0d", 1 << g), first[g], 8 >> g);
            chk($sformatf("sw_s_D%0d", 1 << g), rs[g], es);
            chk($sformatf("sw_c_D%0d", 1 << g), rc[g], ec);
            chk($sformatf("sw_ovf_D%0d", 1 << g), ro[g], eo);
        end
        chk("sw_busy_end", sw_busy, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; x = '0; y = '0; add_n = 1'b0;
        sw_reset = 1'b1; sw_start = 1'b0; sw_x = '0; sw_y = '0; sw_add = 1'b0;
        exp_s_held = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_s", s, 0);
        chk("rst_c_out", c_out, 0);
        chk("rst_ovf", ovf, 0);
        reset = 1'b0; sw_reset = 1'b0;
        @(negedge clk);

        // Directed cases
        run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'h0005, 16'h0007, 1'b1, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b1, 1'b0);
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0);
        run_op(16'h7FFF, 16'hFFFF, 1'b1, 1'b0);

        // Random single operations
        for (int i = 0; i < 20; i++)
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);

        // start held high: back-to-back, garbage operands during RUN
        for (int i = 0; i < 6; i++)
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
        run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);

        // Reset during the second RUN cycle
        x = 16'h4321; y = 16'h1111; add_n = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_s", s, 0);
        chk("mid_rst_c_out", c_out, 0);
        chk("mid_rst_ovf", ovf, 0);
        reset = 1'b0;
        exp_s_held = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_no_done", done, 0);
            chk("post_rst_busy", busy, 0);
        end
        run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0);

        // N=8 sweep over D in {1,2,4,8}: corners then random
        sweep_op(8'h00, 8'h00, 1'b0);
        sweep_op(8'h00, 8'h00, 1'b1);
        sweep_op(8'h7F, 8'h01, 1'b0);
        sweep_op(8'h80, 8'h01, 1'b1);
        sweep_op(8'hFF, 8'h01, 1'b0);
        sweep_op(8'hFF, 8'hFF, 1'b1);
        sweep_op(8'h80, 8'h7F, 1'b1);
        sweep_op(8'h05, 8'h07, 1'b1);
        for (int i = 0; i < 300; i++)
            sweep_op(8'($urandom), 8'($urandom), 1'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
